// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU control stage and the ALU itself:
//   - alu_op_e     : 3-bit ALU operation codes
//   - OPC_*        : major opcodes (R, I-arith, load, store, branch)
//   - F7_* / F3_*  : funct7 / funct3 field values used by the decoder
//   - ctrl_word_t  : decoded control word held in the stage registers
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA variants
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;        // lw / sw
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef struct packed {
    logic [2:0] ctr;
    logic       src;
    logic       ill;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_RESET = '{ctr: 3'b000, src: 1'b0, ill: 1'b0};

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational instruction -> ALU control decode.
// Ports:
//   instr_i      [31:0] instruction word
//   alu_ctr_o    [2:0]  ALU operation code
//   alu_src_o           1 = immediate second operand, 0 = rs2
//   illegal_o           instruction is not a supported opcode/funct combo
// Unsupported encodings fall back to ADD with rs2 operand and flag illegal.
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [2:0]  alu_ctr_o,
  output logic        alu_src_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    op;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Register and immediate fields play no part in ALU control selection.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    op        = ALU_ADD;
    alu_src_o = 1'b0;
    illegal_o = 1'b1;
    case (opcode)
      OPC_R: begin
        illegal_o = 1'b0;
        if      (funct7 == F7_BASE   && funct3 == F3_AND) op = ALU_AND;
        else if (funct7 == F7_BASE   && funct3 == F3_XOR) op = ALU_XOR;
        else if (funct7 == F7_BASE   && funct3 == F3_SLL) op = ALU_SLL;
        else if (funct7 == F7_BASE   && funct3 == F3_ADD) op = ALU_ADD;
        else if (funct7 == F7_ALT    && funct3 == F3_ADD) op = ALU_SUB;
        else if (funct7 == F7_MULDIV && funct3 == F3_ADD) op = ALU_MUL;
        else illegal_o = 1'b1;
      end
      OPC_I_ARITH: begin
        // ADDI ignores funct7: those bits belong to the immediate.
        if (funct3 == F3_ADD) begin
          op        = ALU_ADDI;
          alu_src_o = 1'b1;
          illegal_o = 1'b0;
        end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
          op        = ALU_SRAI;
          alu_src_o = 1'b1;
          illegal_o = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        // Address generation is base + offset.
        if (funct3 == F3_WORD) begin
          alu_src_o = 1'b1;
          illegal_o = 1'b0;
        end
      end
      OPC_BRANCH: begin
        // Equality compare via subtraction of rs1 - rs2.
        if (funct3 == F3_BEQ) begin
          op        = ALU_SUB;
          illegal_o = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign alu_ctr_o = op;

endmodule

// File: rtl/alu_ctrl_stage.sv
// ---------------------------------------------------------------------------
// alu_ctrl_stage
// Decode-and-register stage producing ALU control words, with a two-entry
// skid buffer (main register M drives outputs, skid register S catches the
// word accepted while M is stalled).
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-low reset
//   flush_i            synchronous flush, drops every held entry
//   valid_i / instr_i  upstream instruction; ready_o = S empty
//   valid_o / ready_i  downstream handshake; valid_o = M full
//   ALUCtr_o [2:0]     ALU operation code
//   ALUSrc_o           1 = immediate operand
//   illegal_o          held instruction is unsupported
// Only INSTR_W = 32 is supported.
// ---------------------------------------------------------------------------
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               ready_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2:0]         ALUCtr_o,
  output logic               ALUSrc_o,
  output logic               illegal_o
);

  ctrl_word_t dec_word;
  ctrl_word_t m_q, m_d;
  ctrl_word_t s_q, s_d;
  logic       m_valid_q, m_valid_d;
  logic       s_valid_q, s_valid_d;
  logic       in_xfer;
  logic       out_xfer;

  alu_ctrl_decode u_decode (
    .instr_i   (instr_i),
    .alu_ctr_o (dec_word.ctr),
    .alu_src_o (dec_word.src),
    .illegal_o (dec_word.ill)
  );

  assign in_xfer  = valid_i && !s_valid_q;
  assign out_xfer = m_valid_q && ready_i;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (s_valid_q) begin
        // Refill M from the skid; no accept can coincide since ready_o = 0.
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (in_xfer) begin
        m_d = dec_word;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!m_valid_q) begin
        m_d       = dec_word;
        m_valid_d = 1'b1;
      end else begin
        // M is stalled: park the new word in S, which drops ready_o.
        s_d       = dec_word;
        s_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      m_q       <= CTRL_RESET;
      s_q       <= CTRL_RESET;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign ready_o   = !s_valid_q;
  assign valid_o   = m_valid_q;
  assign ALUCtr_o  = m_q.ctr;
  assign ALUSrc_o  = m_q.src;
  assign illegal_o = m_q.ill;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_stage
// Scoreboard bench: accepted instructions push their expected control word
// (from an instruction-table reference) into a queue; a negedge monitor
// compares the held output against the queue head and pops on delivery.
// Occupancy of the queue predicts valid_o / ready_o each cycle.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic [31:0] instr;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [2:0]  alu_ctr;
  logic        alu_src;
  logic        illegal;

  int checks   = 0;
  int failures = 0;
  int delivered = 0;

  logic [4:0] sb[$];
  bit         reset_pending = 1'b0;
  bit         rst_done      = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.INSTR_W(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .flush_i   (flush),
    .valid_i   (valid_in),
    .instr_i   (instr),
    .ready_o   (ready_out),
    .valid_o   (valid_out),
    .ready_i   (ready_in),
    .ALUCtr_o  (alu_ctr),
    .ALUSrc_o  (alu_src),
    .illegal_o (illegal)
  );

  // Reference: {ALUCtr, ALUSrc, illegal} straight from the instruction table.
  function automatic logic [4:0] ref_ctrl(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) return {3'd0, 1'b0, 1'b0};
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) return {3'd1, 1'b0, 1'b0};
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) return {3'd2, 1'b0, 1'b0};
    if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) return {3'd3, 1'b0, 1'b0};
    if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return {3'd4, 1'b0, 1'b0};
    if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) return {3'd5, 1'b0, 1'b0};
    if (op == 7'h13 && f3 == 3'd0)                return {3'd6, 1'b1, 1'b0};
    if (op == 7'h13 && f7 == 7'h20 && f3 == 3'd5) return {3'd7, 1'b1, 1'b0};
    if (op == 7'h03 && f3 == 3'd2)                return {3'd3, 1'b1, 1'b0};
    if (op == 7'h23 && f3 == 3'd2)                return {3'd3, 1'b1, 1'b0};
    if (op == 7'h63 && f3 == 3'd0)                return {3'd4, 1'b0, 1'b0};
    return {3'd3, 1'b0, 1'b1};
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    logic [4:0] rs2, rs1, rd;
    rs2 = 5'($urandom);
    rs1 = 5'($urandom);
    rd  = 5'($urandom);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 13))
      0:  return enc(7'h00, 3'd0, 7'h33);
      1:  return enc(7'h20, 3'd0, 7'h33);
      2:  return enc(7'h01, 3'd0, 7'h33);
      3:  return enc(7'h00, 3'd7, 7'h33);
      4:  return enc(7'h00, 3'd4, 7'h33);
      5:  return enc(7'h00, 3'd1, 7'h33);
      6:  return enc(7'($urandom), 3'd0, 7'h13);
      7:  return enc(7'h20, 3'd5, 7'h13);
      8:  return enc(7'($urandom), 3'd2, 7'h03);
      9:  return enc(7'($urandom), 3'd2, 7'h23);
      10: return enc(7'($urandom), 3'd0, 7'h63);
      11: return enc(7'($urandom), 3'($urandom), 7'h33);
      12: return enc(7'($urandom), 3'($urandom), 7'h13);
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    if (reset_pending) begin
      check("reset_valid_o", {31'd0, valid_out}, 32'd0);
      check("reset_ready_o", {31'd0, ready_out}, 32'd1);
      check("reset_fields", {27'd0, alu_ctr, alu_src, illegal}, 32'd0);
      rst_done = 1'b1;
    end
    if (rst_done) begin
      check("valid_o", {31'd0, valid_out}, {31'd0, sb.size() > 0});
      check("ready_o", {31'd0, ready_out}, {31'd0, sb.size() < 2});
      if (valid_out && sb.size() > 0) begin
        check("ctrl_word", {27'd0, alu_ctr, alu_src, illegal}, {27'd0, sb[0]});
        if (ready_in) begin
          delivered++;
          $display("deliver %0d: ALUCtr=%03b ALUSrc=%0b illegal=%0b",
                   delivered, alu_ctr, alu_src, illegal);
          void'(sb.pop_front());
        end
      end
      if (valid_in && ready_out) sb.push_back(ref_ctrl(instr));
      if (flush) sb.delete();
    end
    if (!rst_n) sb.delete();
    reset_pending = !rst_n;
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy,
                     input logic fl, input logic rs);
    valid_in = v;
    instr    = ins;
    ready_in = rdy;
    flush    = fl;
    rst_n    = rs;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seq_b2b[7];
  logic [31:0] i_and, i_sll, i_srai_bad, i_sub;

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; instr = '0; ready_in = 1'b0;
    i_sub      = 32'h4000_0033;
    i_and      = enc(7'h00, 3'd7, 7'h33);
    i_sll      = enc(7'h00, 3'd1, 7'h33);
    i_srai_bad = enc(7'h00, 3'd5, 7'h13);
    seq_b2b[0] = enc(7'h00, 3'd0, 7'h33);   // add
    seq_b2b[1] = enc(7'h00, 3'd4, 7'h33);   // xor
    seq_b2b[2] = enc(7'h01, 3'd0, 7'h33);   // mul
    seq_b2b[3] = enc(7'h15, 3'd0, 7'h13);   // addi
    seq_b2b[4] = enc(7'h20, 3'd5, 7'h13);   // srai
    seq_b2b[5] = enc(7'h00, 3'd2, 7'h03);   // lw
    seq_b2b[6] = enc(7'h00, 3'd0, 7'h63);   // beq

    cyc(0, '0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);

    // Single sub.
    cyc(1, i_sub, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 7; i++) cyc(1, seq_b2b[i], 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);

    // Stall: and held in M, sll in S, third offer refused.
    cyc(1, i_and, 0, 0, 1);
    cyc(1, i_sll, 0, 0, 1);
    cyc(1, i_sub, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 1);

    // Illegal encodings.
    cyc(1, 32'h0000_007F, 1, 0, 1);
    cyc(1, i_srai_bad, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);

    // Flush with both registers full and a live offer.
    cyc(1, i_and, 0, 0, 1);
    cyc(1, i_sll, 0, 0, 1);
    cyc(1, i_sub, 1, 1, 1);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);

    // Reset mid-stream while stalled.
    cyc(1, i_and, 0, 0, 1);
    cyc(1, i_sll, 0, 0, 1);
    cyc(1, i_sub, 0, 0, 0);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 99) < 3), !($urandom_range(0, 199) < 2));
    end

    // Drain.
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 1);
    check("drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
